// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : Shared definitions for the VGA frame-buffer read side:
//             default 640x480@60 timing constants, the per-pixel control
//             bundle carried down the alignment pipeline, and the
//             RGB332 -> RGB444 colour expansion.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package vga_pkg;

  // Default horizontal timing (pixel clocks)
  localparam int H_ACT_DEF    = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL      = H_ACT_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800
  localparam int H_SYNC_START = H_ACT_DEF + H_FP_DEF;                          // 656
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;                 // 751

  // Default vertical timing (lines)
  localparam int V_ACT_DEF    = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL      = V_ACT_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525
  localparam int V_SYNC_START = V_ACT_DEF + V_FP_DEF;                          // 490
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;                 // 491

  // Control bits travelling alongside the colour data
  typedef struct packed {
    logic hs;   // horizontal sync (already at pin polarity)
    logic vs;   // vertical sync (already at pin polarity)
    logic de;   // active-area flag
    logic fs;   // first active pixel of the frame
  } vga_ctl_t;

  // RGB332 -> RGB444: replicate the MSBs into the missing low bits so that
  // full-scale codes map to full-scale output.
  function automatic logic [11:0] rgb332_to_444(input logic [7:0] d);
    return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing
//  Purpose  : Horizontal/vertical raster counters and the raw (stage-0)
//             timing flags derived from them.
//  Ports    : clk, rst      clock / synchronous active-high reset
//             o_col         current h count divided by 4 (image column)
//             o_active      counters inside the visible area
//             o_first       counters at (0,0)
//             o_hsync       raw hsync at pin polarity
//             o_vsync       raw vsync at pin polarity
//             o_row_adv     last clock of a line that ends a 4-line image row
//             o_row_clr     last clock of the frame
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACT    = H_ACT_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACT    = V_ACT_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0,
  parameter int COL_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic [COL_W-1:0] o_col,
  output logic             o_active,
  output logic             o_first,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_row_adv,
  output logic             o_row_clr
);

  localparam int HTOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int VTOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW   = $clog2(HTOT);
  localparam int VW   = $clog2(VTOT);

  localparam logic [HW-1:0] c_h_last     = HW'(HTOT - 1);
  localparam logic [HW-1:0] c_h_act      = HW'(H_ACT);
  localparam logic [HW-1:0] c_hs_start   = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] c_hs_end     = HW'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] c_v_last     = VW'(VTOT - 1);
  localparam logic [VW-1:0] c_v_act      = VW'(V_ACT);
  localparam logic [VW-1:0] c_vs_start   = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] c_vs_end     = VW'(V_ACT + V_FP + V_SYNC - 1);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          w_h_last;
  logic          w_v_last;

  assign w_h_last = (r_h == c_h_last);
  assign w_v_last = (r_v == c_v_last);

  // Raster counters: (last,last) -> (0,0) in a single clock
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_last) begin
      r_h <= '0;
      r_v <= w_v_last ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  assign o_col     = r_h[HW-1:2];
  assign o_active  = (r_h < c_h_act) && (r_v < c_v_act);
  assign o_first   = (r_h == '0) && (r_v == '0);
  assign o_hsync   = ((r_h >= c_hs_start) && (r_h <= c_hs_end)) ? SYNC_POL : ~SYNC_POL;
  assign o_vsync   = ((r_v >= c_vs_start) && (r_v <= c_vs_end)) ? SYNC_POL : ~SYNC_POL;
  // Every fourth visible line moves on to the next stored image row
  assign o_row_adv = w_h_last && (r_v[1:0] == 2'b11) && (r_v < c_v_act);
  assign o_row_clr = w_h_last && w_v_last;

endmodule
`default_nettype wire

// File: rtl/vga_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : vga_frame_reader
//  Purpose  : Read side of a 160x120 RGB332 frame buffer. Generates VGA
//             timing, issues 4x4-upscaled read addresses and drives sync,
//             data-enable and RGB444 colour to the DAC pins.
//  Ports    : clk          pixel clock (also the buffer read clock)
//             rst          synchronous active-high reset
//             addr_out     registered buffer read address (idle = all ones)
//             data_in      buffer read data, valid 1 clk after addr_out
//             hsync/vsync  sync outputs, polarity set by SYNC_POL
//             de           active-area flag aligned with colour
//             vga_r/g/b    4-bit colour channels
//             frame_start  1-clk pulse with output pixel (0,0)
//  Latency  : counters at n -> addr_out n+1 -> data_in n+2 -> pins n+3
//  Revision : 1.0  initial release
// ============================================================================
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int AW       = 15,
  parameter int DW       = 8,
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 120,
  parameter int H_ACT    = H_ACT_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACT    = V_ACT_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] addr_out,
  input  logic [DW-1:0] data_in,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b,
  output logic          frame_start
);

  localparam int COL_W = $clog2(H_ACT + H_FP + H_SYNC + H_BP) - 2;

  localparam logic [AW-1:0] c_idle_addr     = '1;
  localparam logic [AW-1:0] c_img_w         = AW'(IMG_W);
  localparam logic [AW-1:0] c_last_row_base = AW'((IMG_H - 1) * IMG_W);
  localparam vga_ctl_t      c_ctl_idle      = '{hs: ~SYNC_POL, vs: ~SYNC_POL, de: 1'b0, fs: 1'b0};

  logic [COL_W-1:0] w_col;
  logic             w_active;
  logic             w_first;
  logic             w_hsync;
  logic             w_vsync;
  logic             w_row_adv;
  logic             w_row_clr;
  vga_ctl_t         w_ctl0;

  logic [AW-1:0]    r_row_base;
  logic [AW-1:0]    r_addr;
  vga_ctl_t         r_ctl1;
  vga_ctl_t         r_ctl2;
  vga_ctl_t         r_ctl3;
  logic [11:0]      r_rgb;

  vga_timing #(
    .H_ACT    (H_ACT),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACT    (V_ACT),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL),
    .COL_W    (COL_W)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .o_col     (w_col),
    .o_active  (w_active),
    .o_first   (w_first),
    .o_hsync   (w_hsync),
    .o_vsync   (w_vsync),
    .o_row_adv (w_row_adv),
    .o_row_clr (w_row_clr)
  );

  assign w_ctl0 = '{hs: w_hsync, vs: w_vsync, de: w_active, fs: w_first & w_active};

  // Row base tracks (v>>2)*IMG_W by adding IMG_W every fourth line, which
  // avoids a multiplier. It is clamped at the last image row so a taller
  // raster can never walk the address past the stored picture.
  always_ff @(posedge clk) begin
    if (rst || w_row_clr) begin
      r_row_base <= '0;
    end else if (w_row_adv && (r_row_base != c_last_row_base)) begin
      r_row_base <= r_row_base + c_img_w;
    end
  end

  // Stage 1: read address plus control
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= c_idle_addr;
      r_ctl1 <= c_ctl_idle;
    end else begin
      r_addr <= w_active ? (r_row_base + AW'(w_col)) : c_idle_addr;
      r_ctl1 <= w_ctl0;
    end
  end

  // Stage 2: control waits while the buffer returns data
  // Stage 3: pin registers, colour forced black outside the active area
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctl2 <= c_ctl_idle;
      r_ctl3 <= c_ctl_idle;
      r_rgb  <= '0;
    end else begin
      r_ctl2 <= r_ctl1;
      r_ctl3 <= r_ctl2;
      r_rgb  <= r_ctl2.de ? rgb332_to_444(data_in) : 12'h000;
    end
  end

  assign addr_out    = r_addr;
  assign hsync       = r_ctl3.hs;
  assign vsync       = r_ctl3.vs;
  assign de          = r_ctl3.de;
  assign frame_start = r_ctl3.fs;
  assign vga_r       = r_rgb[11:8];
  assign vga_g       = r_rgb[7:4];
  assign vga_b       = r_rgb[3:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_frame_reader
//  Purpose  : Directed self-checking bench for vga_frame_reader. Horizontal
//             timing is the real 800-clock line; the frame is shortened to
//             22 lines (16 visible) so several whole frames fit in the run.
//             A second instance is built with SYNC_POL=1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_frame_reader;

  localparam int AW   = 15;
  localparam int VACT = 16;
  localparam int VFP  = 2;
  localparam int VSY  = 2;
  localparam int VBP  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr0, addr1;
  logic [7:0]    data0 = 8'h00, data1 = 8'h00;
  logic          hs0, vs0, de0, fs0;
  logic          hs1, vs1, de1, fs1;
  logic [3:0]    r0, g0, b0, r1, g1, b1;
  logic [7:0]    ram0_val = 8'h00;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #20 clk = ~clk;

  vga_frame_reader #(.V_ACT(VACT), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .addr_out(addr0), .data_in(data0), .hsync(hs0), .vsync(vs0),
    .de(de0), .vga_r(r0), .vga_g(g0), .vga_b(b0), .frame_start(fs0));

  vga_frame_reader #(.V_ACT(VACT), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .addr_out(addr1), .data_in(data1), .hsync(hs1), .vsync(vs1),
    .de(de1), .vga_r(r1), .vga_g(g1), .vga_b(b1), .frame_start(fs1));

  // Buffer model: 1-clk read latency, ram[a] = a[7:0], last word black,
  // word 0 programmable for the colour-expansion checks.
  function automatic logic [7:0] ram_rd(input logic [AW-1:0] a);
    if (a == 15'h7FFF) return 8'h00;
    if (a == 15'h0000) return ram0_val;
    return a[7:0];
  endfunction

  always @(posedge clk) begin
    data0 <= ram_rd(addr0);
    data1 <= ram_rd(addr1);
  end

  // Expected colour for output pixel (x,y) of the 4x4-upscaled image
  function automatic logic [11:0] exp_pix(input int x, input int y);
    logic [AW-1:0] a;
    logic [7:0]    d;
    a = AW'((y / 4) * 160 + (x / 4));
    d = ram_rd(a);
    return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_to(input int k);
    while (cyc < k) step();
  endtask

  initial begin
    int f1, lo, den, hi1, fsn, fsat, guard;
    logic p;

    // ---- Reset state ----
    repeat (3) step();
    chk("rst_addr", addr0, 15'h7FFF);
    chk("rst_hs",   hs0, 1'b1);
    chk("rst_vs",   vs0, 1'b1);
    chk("rst_de",   de0, 1'b0);
    chk("rst_rgb",  {r0, g0, b0}, 12'h000);
    chk("rst_fs",   fs0, 1'b0);
    chk("rst_hs1",  hs1, 1'b0);
    chk("rst_vs1",  vs1, 1'b0);

    // ---- Release: counters restart at (0,0), pins follow 3 clocks later ----
    rst = 1'b0;
    cyc = 0;
    wait_to(1);
    chk("addr_first", addr0, 15'h0000);
    wait_to(2);
    chk("de_early", de0, 1'b0);
    wait_to(3);
    chk("de_rise", de0, 1'b1);
    chk("fs_rise", fs0, 1'b1);
    for (int k = 3; k <= 10; k++) begin
      wait_to(k);
      chk("pix_line0", {r0, g0, b0}, exp_pix(k - 3, 0));
      if (k == 4) chk("fs_once", fs0, 1'b0);
    end

    // ---- Horizontal blanking of line 0 ----
    for (int k = 641; k <= 802; k++) begin
      wait_to(k);
      if (k <= 800) chk("blank_addr", addr0, 15'h7FFF);
      if (k >= 643) begin
        chk("blank_rgb", {r0, g0, b0}, 12'h000);
        chk("blank_de",  de0, 1'b0);
      end
    end

    // ---- Line period, hsync width, de count ----
    guard = 0;
    do begin p = hs0; step(); guard++; end while (!(p && !hs0) && guard < 2000);
    chk("hs_found", guard < 2000, 1'b1);
    f1 = cyc; lo = 0; den = 0; hi1 = 0; guard = 0;
    do begin
      if (!hs0) lo++;
      if (de0)  den++;
      if (hs1)  hi1++;
      p = hs0; step(); guard++;
    end while (!(p && !hs0) && guard < 2000);
    chk("hs_period", cyc - f1, 800);
    chk("hs_width",  lo, 96);
    chk("de_count",  den, 640);
    chk("hs1_width", hi1, 96);

    // ---- Upscale ----
    wait_to(2406);
    chk("pix_3_3", {r0, g0, b0}, exp_pix(3, 3));
    wait_to(2410);
    chk("pix_4_3", {r0, g0, b0}, 12'h005);
    wait_to(3201);
    chk("addr_line4", addr0, 15'd160);
    wait_to(3203);
    chk("pix_0_4", {r0, g0, b0}, 12'hB00);
    wait_to(12640);
    chk("addr_last", addr0, 15'd639);
    wait_to(12642);
    chk("pix_last", {r0, g0, b0}, 12'h6FF);
    chk("de_last",  de0, 1'b1);
    wait_to(12643);
    chk("de_fall",  de0, 1'b0);

    // ---- Frame period, vsync width, frame_start once per frame ----
    guard = 0;
    do begin p = vs0; step(); guard++; end while (!(p && !vs0) && guard < 20000);
    chk("vs_found", guard < 20000, 1'b1);
    f1 = cyc; lo = 0; hi1 = 0; fsn = 0; fsat = 0; guard = 0;
    do begin
      if (!vs0) lo++;
      if (vs1)  hi1++;
      if (fs0) begin fsn++; fsat = cyc; end
      p = vs0; step(); guard++;
    end while (!(p && !vs0) && guard < 20000);
    chk("vs_period", cyc - f1, 17600);
    chk("vs_width",  lo, 1600);
    chk("vs1_width", hi1, 1600);
    chk("fs_count",  fsn, 1);
    chk("fs_cycle",  fsat, 17603);

    // ---- Colour expansion through word 0 ----
    ram0_val = 8'hFF;
    wait_to(35203);
    chk("rgb_ff", {r0, g0, b0}, 12'hFFF);
    wait_to(35500);
    ram0_val = 8'hE0;
    wait_to(36003);
    chk("rgb_e0", {r0, g0, b0}, 12'hF00);

    // ---- Mid-frame reset with counters at (300,10) ----
    wait_to(35200 + 10 * 800 + 300);
    chk("pre_rst_de", de0, 1'b1);
    rst = 1'b1;
    step();
    chk("mrst_addr", addr0, 15'h7FFF);
    chk("mrst_de",   de0, 1'b0);
    chk("mrst_rgb",  {r0, g0, b0}, 12'h000);
    chk("mrst_hs",   hs0, 1'b1);
    chk("mrst_vs",   vs0, 1'b1);
    chk("mrst_fs",   fs0, 1'b0);
    step();
    rst = 1'b0;
    cyc = 0;
    wait_to(2);
    chk("mrel_de_early", de0, 1'b0);
    wait_to(3);
    chk("mrel_fs", fs0, 1'b1);
    chk("mrel_de", de0, 1'b1);
    fsn = 0; fsat = 0;
    while (cyc < 3 + 17600) begin
      step();
      if (fs0) begin fsn++; fsat = cyc; end
    end
    chk("mrel_fs_count", fsn, 1);
    chk("mrel_fs_cycle", fsat, 17603);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
